norm_arbiter: RTL and testbench

NORM_ARBITER -- requirements
Module: norm_arbiter

---
 rtl/norm_arbiter_if.sv | 51 +++++
 rtl/norm_arbiter.sv | 110 +++++++++++
 tb/tb_norm_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/norm_arbiter_if.sv
// Handshake and datapath bundle between two requesting lanes, the shared
// normalizer and the result consumer of norm_arbiter.
interface norm_arbiter_if #(
   parameter int EXP_W = 10,
   parameter int TAG_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [49:0]      req0_m;
   logic [EXP_W-1:0] req0_exp;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [49:0]      req1_m;
   logic [EXP_W-1:0] req1_exp;
   logic [TAG_W-1:0] req1_tag;

   logic [49:0]      norm_m_in;
   logic [26:0]      norm_m_out;
   logic [5:0]       norm_zero_cnt;
   logic             norm_en;

   logic             out_valid;
   logic             out_ready;
   logic [26:0]      out_m;
   logic [EXP_W-1:0] out_exp;
   logic             out_src;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;

   modport slave (
      input  req0_valid, req0_m, req0_exp, req0_tag,
      input  req1_valid, req1_m, req1_exp, req1_tag,
      output req0_ready, req1_ready,
      output norm_m_in,
      input  norm_m_out, norm_zero_cnt, norm_en,
      output out_valid, out_m, out_exp, out_src, out_tag, out_zero,
      input  out_ready
   );

   modport master (
      output req0_valid, req0_m, req0_exp, req0_tag,
      output req1_valid, req1_m, req1_exp, req1_tag,
      input  req0_ready, req1_ready,
      input  norm_m_in,
      output norm_m_out, norm_zero_cnt, norm_en,
      input  out_valid, out_m, out_exp, out_src, out_tag, out_zero,
      output out_ready
   );
endinterface

// File: rtl/norm_arbiter.sv
// Two-lane round-robin arbiter feeding a shared mantissa normalizer, with an
// operand stage (A) and a result stage (B) under valid/ready flow control.
module norm_arbiter #(
   parameter int EXP_W = 10,
   parameter int TAG_W = 4
) (
   input logic          clk,
   input logic          rst,
   norm_arbiter_if.slave bus
);

   logic             vld_p0;
   logic [49:0]      m_p0;
   logic [EXP_W-1:0] exp_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             src_p0;

   logic             vld_p1;
   logic [26:0]      m_p1;
   logic [EXP_W-1:0] exp_p1;
   logic [TAG_W-1:0] tag_p1;
   logic             src_p1;
   logic             zero_p1;

   logic last_grant;
   logic grant;
   logic b_load;
   logic a_free;
   logic hs;

   function automatic logic [EXP_W-1:0] adj_exp(input logic [EXP_W-1:0] e,
                                                 input logic [5:0]       cnt,
                                                 input logic             right);
      logic [EXP_W-1:0] c;
      c = EXP_W'(cnt);
      return right ? (e + c) : (e - c);
   endfunction

   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
      else if (bus.req1_valid)              grant = 1'b1;
   end

   assign b_load = !vld_p1 || bus.out_ready;
   assign a_free = !vld_p0 || b_load;

   // Ready is held low throughout reset, not just after the first edge.
   assign bus.req0_ready = !rst && a_free && bus.req0_valid && !grant;
   assign bus.req1_ready = !rst && a_free && bus.req1_valid &&  grant;
   assign hs             = bus.req0_ready || bus.req1_ready;

   // Stage A: operand capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0     <= 1'b0;
         m_p0       <= '0;
         exp_p0     <= '0;
         tag_p0     <= '0;
         src_p0     <= 1'b0;
         last_grant <= 1'b1;
      end else if (hs) begin
         vld_p0     <= 1'b1;
         m_p0       <= grant ? bus.req1_m   : bus.req0_m;
         exp_p0     <= grant ? bus.req1_exp : bus.req0_exp;
         tag_p0     <= grant ? bus.req1_tag : bus.req0_tag;
         src_p0     <= grant;
         last_grant <= grant;
      end else if (b_load) begin
         vld_p0     <= 1'b0;
      end
   end

   assign bus.norm_m_in = m_p0;

   // Stage B: normalized result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         m_p1    <= '0;
         exp_p1  <= '0;
         tag_p1  <= '0;
         src_p1  <= 1'b0;
         zero_p1 <= 1'b0;
      end else if (b_load) begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            tag_p1 <= tag_p0;
            src_p1 <= src_p0;
            if (m_p0 == '0) begin
               m_p1    <= '0;
               exp_p1  <= '0;
               zero_p1 <= 1'b1;
            end else begin
               m_p1    <= bus.norm_m_out;
               exp_p1  <= adj_exp(exp_p0, bus.norm_zero_cnt, bus.norm_en);
               zero_p1 <= 1'b0;
            end
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_m     = m_p1;
   assign bus.out_exp   = exp_p1;
   assign bus.out_src   = src_p1;
   assign bus.out_tag   = tag_p1;
   assign bus.out_zero  = zero_p1;

endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter with a behavioural normalizer that aligns
// the leading one to bit 46.
module tb_norm_arbiter;
   localparam int EXP_W = 10;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_bad = 0;

   norm_arbiter_if #(.EXP_W(EXP_W), .TAG_W(TAG_W)) bus ();

   norm_arbiter #(.EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] nrm_sh(input logic [49:0] m);
      int p;
      p = 0;
      for (int i = 0; i < 50; i++) if (m[i]) p = i;
      if (p > 46) return {1'b1, 6'(p - 46)};
      return {1'b0, 6'(46 - p)};
   endfunction

   function automatic logic [26:0] nrm_m(input logic [49:0] m);
      logic [6:0]  sh;
      logic [49:0] s;
      logic        lost;
      sh   = nrm_sh(m);
      lost = 1'b0;
      if (sh[6]) begin
         s    = m >> sh[5:0];
         lost = |(m & ((50'd1 << sh[5:0]) - 50'd1));
      end else begin
         s = m << sh[5:0];
      end
      return {s[46:21], (|s[20:0]) | lost};
   endfunction

   always_comb begin
      bus.norm_m_out    = nrm_m(bus.norm_m_in);
      bus.norm_zero_cnt = nrm_sh(bus.norm_m_in)[5:0];
      bus.norm_en       = nrm_sh(bus.norm_m_in)[6];
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic drive(input int lane, input logic v, input logic [49:0] m,
                        input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] t);
      if (lane == 0) begin
         bus.req0_valid = v; bus.req0_m = m; bus.req0_exp = e; bus.req0_tag = t;
      end else begin
         bus.req1_valid = v; bus.req1_m = m; bus.req1_exp = e; bus.req1_tag = t;
      end
   endtask

   // Starts and ends on a falling edge; one operand on one lane, unstalled.
   task automatic run_one(input string nm, input int lane, input logic [49:0] m,
                          input logic [EXP_W-1:0] e, input logic [TAG_W-1:0] t,
                          input logic [EXP_W-1:0] xe, input logic xz);
      drive(lane, 1'b1, m, e, t);
      #1;
      chk({nm, "_rdy"}, 64'(lane == 0 ? bus.req0_ready : bus.req1_ready), 64'd1);
      @(negedge clk);
      drive(lane, 1'b0, m, e, t);
      chk({nm, "_vld_early"}, 64'(bus.out_valid), 64'd0);
      chk({nm, "_nmin"}, 64'(bus.norm_m_in), 64'(m));
      @(negedge clk);
      chk({nm, "_vld"},  64'(bus.out_valid), 64'd1);
      chk({nm, "_exp"},  64'(bus.out_exp),   64'(xe));
      chk({nm, "_m"},    64'(bus.out_m),     xz ? 64'd0 : 64'(nrm_m(m)));
      chk({nm, "_src"},  64'(bus.out_src),   64'(lane));
      chk({nm, "_tag"},  64'(bus.out_tag),   64'(t));
      chk({nm, "_zero"}, 64'(bus.out_zero),  64'(xz));
      @(negedge clk);
      chk({nm, "_drain"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.out_ready = 1'b0;
      drive(0, 1'b1, 50'd1, '0, '0);
      drive(1, 1'b1, 50'd1, '0, '0);
      #2;
      chk("rst_rdy0",  64'(bus.req0_ready), 64'd0);
      chk("rst_rdy1",  64'(bus.req1_ready), 64'd0);
      chk("rst_vld",   64'(bus.out_valid),  64'd0);
      chk("rst_nmin",  64'(bus.norm_m_in),  64'd0);
      chk("rst_m",     64'(bus.out_m),      64'd0);
      chk("rst_exp",   64'(bus.out_exp),    64'd0);
      chk("rst_tag",   64'(bus.out_tag),    64'd0);
      chk("rst_src",   64'(bus.out_src),    64'd0);
      chk("rst_zero",  64'(bus.out_zero),   64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_rdy", 64'(bus.req0_ready), 64'd0);
      chk("rst_hold_vld", 64'(bus.out_valid),  64'd0);
      @(negedge clk);
      drive(0, 1'b0, 50'd0, '0, '0);
      drive(1, 1'b0, 50'd0, '0, '0);
      bus.out_ready = 1'b1;
      rst = 1'b0;

      run_one("l0_left",  0, 50'd1 << 40, 10'd100,  4'd3, 10'd94,  1'b0);
      run_one("l1_right", 1, 50'd1 << 48, 10'd100,  4'd9, 10'd102, 1'b0);
      run_one("l1_wrap",  1, 50'd1 << 48, 10'd1023, 4'd4, 10'd1,   1'b0);
      run_one("sticky",   0, (50'd1 << 49) | 50'd1, 10'd10, 4'd6, 10'd13, 1'b0);
      run_one("zero",     0, 50'd0,       10'd77,   4'd2, 10'd0,   1'b1);

      // Round-robin with both lanes always requesting
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 11; k++) begin
         drive(0, k < 8, 50'd1 << 46, 10'd20, 4'(k));
         drive(1, k < 8, 50'd1 << 46, 10'd40, 4'(k));
         #1;
         if (k < 8) begin
            chk("fair_rdy0", 64'(bus.req0_ready), 64'(k % 2 == 0));
            chk("fair_rdy1", 64'(bus.req1_ready), 64'(k % 2 == 1));
         end
         if (k >= 2 && k < 10) begin
            chk("fair_vld", 64'(bus.out_valid), 64'd1);
            chk("fair_src", 64'(bus.out_src),   64'((k - 2) % 2));
            chk("fair_tag", 64'(bus.out_tag),   64'(4'(k - 2)));
            chk("fair_exp", 64'(bus.out_exp),   ((k - 2) % 2 == 1) ? 64'd40 : 64'd20);
         end else begin
            chk("fair_idle", 64'(bus.out_valid), 64'd0);
         end
         @(negedge clk);
      end

      // Backpressure: exactly two operands fit, then everything freezes
      bus.out_ready = 1'b0;
      drive(0, 1'b1, 50'd1 << 46, 10'd50, 4'd1);
      drive(1, 1'b1, 50'd1 << 46, 10'd60, 4'd2);
      #1;
      chk("stall_rdy0_a", 64'(bus.req0_ready), 64'd1);
      chk("stall_rdy1_a", 64'(bus.req1_ready), 64'd0);
      @(negedge clk);
      chk("stall_rdy0_b", 64'(bus.req0_ready), 64'd0);
      chk("stall_rdy1_b", 64'(bus.req1_ready), 64'd1);
      chk("stall_vld_b",  64'(bus.out_valid),  64'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("stall_rdy0", 64'(bus.req0_ready), 64'd0);
         chk("stall_rdy1", 64'(bus.req1_ready), 64'd0);
         chk("stall_vld",  64'(bus.out_valid),  64'd1);
         chk("stall_tag",  64'(bus.out_tag),    64'd1);
         chk("stall_src",  64'(bus.out_src),    64'd0);
         chk("stall_exp",  64'(bus.out_exp),    64'd50);
         @(negedge clk);
      end
      drive(0, 1'b0, 50'd0, '0, '0);
      drive(1, 1'b0, 50'd0, '0, '0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("drain_vld", 64'(bus.out_valid), 64'd1);
      chk("drain_src", 64'(bus.out_src),   64'd1);
      chk("drain_tag", 64'(bus.out_tag),   64'd2);
      chk("drain_exp", 64'(bus.out_exp),   64'd60);
      @(negedge clk);
      chk("drain_done", 64'(bus.out_valid), 64'd0);

      // Reset with both stages full and last grant on lane 0
      bus.out_ready = 1'b0;
      drive(1, 1'b1, 50'd1 << 46, 10'd5, 4'd1);
      #1;
      chk("mid_rdy1", 64'(bus.req1_ready), 64'd1);
      @(negedge clk);
      drive(1, 1'b0, 50'd0, '0, '0);
      drive(0, 1'b1, 50'd1 << 46, 10'd6, 4'd2);
      #1;
      chk("mid_rdy0", 64'(bus.req0_ready), 64'd1);
      @(negedge clk);
      chk("mid_full_vld", 64'(bus.out_valid), 64'd1);
      chk("mid_full_tag", 64'(bus.out_tag),   64'd1);
      drive(0, 1'b1, 50'd1 << 44, 10'd30, 4'd7);
      drive(1, 1'b1, 50'd1 << 44, 10'd30, 4'd7);
      rst = 1'b1;
      #1;
      chk("mid_rst_vld",  64'(bus.out_valid),  64'd0);
      chk("mid_rst_rdy0", 64'(bus.req0_ready), 64'd0);
      chk("mid_rst_rdy1", 64'(bus.req1_ready), 64'd0);
      chk("mid_rst_nmin", 64'(bus.norm_m_in),  64'd0);
      chk("mid_rst_tag",  64'(bus.out_tag),    64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("post_rdy0", 64'(bus.req0_ready), 64'd1);
      chk("post_rdy1", 64'(bus.req1_ready), 64'd0);
      chk("post_vld",  64'(bus.out_valid),  64'd0);
      @(negedge clk);
      drive(0, 1'b0, 50'd0, '0, '0);
      drive(1, 1'b0, 50'd0, '0, '0);
      chk("post_stale", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("post_vld2", 64'(bus.out_valid), 64'd1);
      chk("post_tag",  64'(bus.out_tag),   64'd7);
      chk("post_src",  64'(bus.out_src),   64'd0);
      chk("post_exp",  64'(bus.out_exp),   64'd28);
      @(negedge clk);
      chk("post_done", 64'(bus.out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
